// File: rtl/gate_response_checker_pkg.sv
// Shared state encoding and reference truth tables for the gate response checker.
// Truth-table bit i holds the expected gate output for input vector i.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [1:0] TT_NOT1  = 2'b01;

endpackage

// File: rtl/gate_response_checker_settle_timer.sv
// Loadable 4-bit down-counter that times how long each vector settles on the gate.
// expire_o flags the last settle cycle so the caller can move on at the next edge.
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [3:0] load_val_i,
  output logic       expire_o
);

  logic [3:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 4'd0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != 4'd0)) begin
      count_q <= count_q - 4'd1;
    end
  end

  assign expire_o = (count_q == 4'd1);

endmodule

// File: rtl/gate_response_checker.sv
// Sweeps every input vector through a combinational gate, samples its output after a
// settle delay and scores the responses against a latched truth table.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   exp_tt,
  output logic [N_IN-1:0]        stim,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_cnt,
  output logic [N_IN-1:0]        first_err_vec,
  output logic                   first_err_valid
);

  localparam int              V           = 1 << N_IN;
  localparam logic [N_IN-1:0] VEC_LAST    = '1;
  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE_CYC);
  localparam state_e          AFTER_LOAD  = (SETTLE_CYC > 0) ? SETTLE : SAMPLE;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [V-1:0]      exp_q, exp_d;
  logic [N_IN:0]     err_cnt_q, err_cnt_d;
  logic [N_IN-1:0]   first_err_vec_q, first_err_vec_d;
  logic              first_err_valid_q, first_err_valid_d;
  logic              pass_q, pass_d;
  logic              timer_load, timer_dec, timer_expire;
  logic              mismatch;

  settle_timer u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .dec_i      (timer_dec),
    .load_val_i (SETTLE_LOAD),
    .expire_o   (timer_expire)
  );

  assign mismatch = (dut_out != exp_q[vec_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      vec_q             <= '0;
      exp_q             <= '0;
      err_cnt_q         <= '0;
      first_err_vec_q   <= '0;
      first_err_valid_q <= 1'b0;
      pass_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      vec_q             <= vec_d;
      exp_q             <= exp_d;
      err_cnt_q         <= err_cnt_d;
      first_err_vec_q   <= first_err_vec_d;
      first_err_valid_q <= first_err_valid_d;
      pass_q            <= pass_d;
    end
  end

  // The truth table is copied at start so later changes on exp_tt cannot disturb a sweep.
  always_comb begin
    state_d           = state_q;
    vec_d             = vec_q;
    exp_d             = exp_q;
    err_cnt_d         = err_cnt_q;
    first_err_vec_d   = first_err_vec_q;
    first_err_valid_d = first_err_valid_q;
    pass_d            = pass_q;
    timer_load        = 1'b0;
    timer_dec         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          exp_d             = exp_tt;
          vec_d             = '0;
          err_cnt_d         = '0;
          first_err_vec_d   = '0;
          first_err_valid_d = 1'b0;
          pass_d            = 1'b0;
          timer_load        = 1'b1;
          state_d           = AFTER_LOAD;
        end
      end
      SETTLE: begin
        timer_dec = 1'b1;
        if (timer_expire) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch) begin
          err_cnt_d = err_cnt_q + 1'b1;
          if (!first_err_valid_q) begin
            first_err_vec_d   = vec_q;
            first_err_valid_d = 1'b1;
          end
        end
        if (vec_q == VEC_LAST) begin
          state_d = DONE;
        end else begin
          vec_d      = vec_q + 1'b1;
          timer_load = 1'b1;
          state_d    = AFTER_LOAD;
        end
      end
      DONE: begin
        pass_d  = (err_cnt_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stim            = vec_q;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign pass            = pass_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_vec   = first_err_vec_q;
  assign first_err_valid = first_err_valid_q;

endmodule
